lsu: RTL and testbench
======================

# lsu

Load/store unit: the responder side of the execute unit's load/store handshake. It accepts one word-addressed load or store request at a time from the AGU path of the execute stage and runs it on a simple request/grant/response memory bus. It completes the request with a one-cycle ready pulse that carries the read data. It sits between the execute unit and the data memory or bus bridge.

## Interface
- `TIMEOUT`, 255: cycles allowed from bus request to response before an error completion. Used only with `CIRNO_LSU_TIMEOUT_EN`. Range 1..65535.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `hs_ex4ls_val` in 1: request valid. Held by the execute unit until `hs_ls4ex_rdy`.
- `hs_ls4ex_rdy` out 1: one-cycle completion pulse.
- `i_ls_adr` in 32: byte address.
- `i_ls_wdat` in 32: store data, already lane-aligned.
- `i_ls_wen` in 4: byte write enables. Nonzero means store.
- `i_ls_ren` in 1: load.
- `o_ls_rdat` out 32: full read word. Valid while `hs_ls4ex_rdy` is high.
- `o_ls_err` out 1: bus error or timeout. Valid with `hs_ls4ex_rdy`.
- `o_mem_req` out 1: bus request.
- `i_mem_gnt` in 1: request accepted.
- `o_mem_adr` out 32: word address, with `[1:0]` = 0.
- `o_mem_we` out 1: write.
- `o_mem_be` out 4: byte enables. All ones for loads.
- `o_mem_wdat` out 32: write data.
- `i_mem_rvld` in 1: response (read data or write acknowledge).
- `i_mem_rdat` in 32: read data.
- `i_mem_rerr` in 1: response error. Valid with `i_mem_rvld`.

## Operation
- State machine with four states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If `hs_ex4ls_val` and (`i_ls_ren` or `i_ls_wen != 0`): latch the following, then go to REQ.
    - word address `{i_ls_adr[31:2], 2'b00}`
    - `i_ls_wdat`
    - `o_mem_be` = `i_ls_wen`, or 4'hF for a load
    - `o_mem_we` = (`i_ls_wen != 0`)
  - If `hs_ex4ls_val` with no `i_ls_ren` and `i_ls_wen == 0`: go to RESP with no bus access. Read data = 0, err = 0.
  - If both `i_ls_ren` and `i_ls_wen` are set, the store takes priority.
- REQ:
  - `o_mem_req` = 1; bus outputs come from the latched request and are stable until grant.
  - On `i_mem_gnt`, go to WAIT.
  - If `i_mem_gnt` and `i_mem_rvld` arrive in the same cycle, go directly to RESP and capture the response.
- WAIT:
  - On `i_mem_rvld`, capture `i_mem_rdat` (loads only) and `i_mem_rerr`, then go to RESP.
- RESP:
  - `hs_ls4ex_rdy` = 1, then go to IDLE.
  - `o_ls_rdat` holds the captured word. Stores present 0.
- `i_mem_rvld` is ignored in IDLE and RESP. `i_mem_gnt` is ignored outside REQ.
- Request inputs are sampled only in IDLE. Changes while busy have no effect.
- Reset mid-transaction: return to IDLE next cycle, drop `o_mem_req`, clear the latched data. A late response is ignored.
- Reset values: `hs_ls4ex_rdy`, `o_ls_err`, `o_mem_req`, `o_mem_we` = 0; `o_ls_rdat`, `o_mem_adr`, `o_mem_wdat` = 0; `o_mem_be` = 0.

## Timing
- All outputs are registered or decoded from state. There is no combinational path from `hs_ex4ls_val` to `hs_ls4ex_rdy`.
- Request accepted at cycle T: `o_mem_req` high from T+1.
- Grant at cycle G and response at R > G: `hs_ls4ex_rdy` at R+1.
- Best case (grant and response at T+1): `hs_ls4ex_rdy` at T+2.
- No-op request: `hs_ls4ex_rdy` at T+1.
- At most one transaction is outstanding.
- Back-to-back: IDLE follows RESP, so the next accept occurs at RESP+1 at the earliest.

## Configuration
- `CIRNO_LSU_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the counter reaches `TIMEOUT - 1` without a response, go to RESP with `o_ls_err` = 1 and rdat = 0.
  - `o_mem_req` drops on that transition.
  - A real response in the same cycle as the timeout wins.
- `CIRNO_LSU_TIMEOUT_EN` undefined:
  - No counter. REQ and WAIT wait indefinitely.
  - `o_ls_err` reflects only `i_mem_rerr`.

## Test plan
- Load with 1-cycle memory:
  - Stimulus: adr = 0x1003, ren = 1. Grant at T+1, rvld at T+2 with rdat = 0xDEADBEEF.
  - Required: `o_mem_adr` = 0x1000, be = 4'hF, we = 0; rdy at T+3 with rdat = 0xDEADBEEF, err = 0.
- Store:
  - Stimulus: wen = 4'b1100, wdat = 0xAABB0000. Grant is delayed 3 cycles, then rvld.
  - Required: req is held and bus outputs are stable for the 3 cycles; we = 1, be = 4'b1100; one rdy pulse with rdat = 0.
- Same-cycle grant and response:
  - Stimulus: gnt and rvld both at T+1, with rerr = 1.
  - Required: rdy at T+2 with err = 1.
- No-op and back-to-back:
  - Stimulus: val with ren = 0, wen = 0, then a load held on val.
  - Required: rdy at T+1, no req; the second request is accepted at T+2.
- Reset mid-WAIT, then a stray response:
  - Stimulus: `rst` asserted in WAIT, then rvld arrives in IDLE.
  - Required: req = 0 and state IDLE next cycle; no rdy pulse.
- Timeout with `CIRNO_LSU_TIMEOUT_EN` and TIMEOUT = 4:
  - Stimulus: grant is never given.
  - Required: rdy with err = 1 and rdat = 0, five cycles after accept.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: serves one execute-stage load/store over a req/gnt/rvld memory bus.
// Optional bus watchdog enabled by defining CIRNO_LSU_TIMEOUT_EN (limit set by TIMEOUT).
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_ex4ls_val,
  output logic        hs_ls4ex_rdy,
  input  logic [31:0] i_ls_adr,
  input  logic [31:0] i_ls_wdat,
  input  logic [3:0]  i_ls_wen,
  input  logic        i_ls_ren,
  output logic [31:0] o_ls_rdat,
  output logic        o_ls_err,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic [31:0] o_mem_adr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdat,
  input  logic        i_mem_rvld,
  input  logic [31:0] i_mem_rdat,
  input  logic        i_mem_rerr
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t state;
  state_t state_nxt;

  logic is_store;
  logic accept;
  logic capture;
  logic timeout_fire;
  logic timeout_hit;

  // Address byte offset is dropped: the bus is word addressed.
  logic unused_adr_lo;
  assign unused_adr_lo = ^i_ls_adr[1:0];

  assign is_store = |i_ls_wen;

  // Out-of-range TIMEOUT values leave this marker block in the elaborated hierarchy.
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_out_of_range
  end

`ifdef CIRNO_LSU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Cycles spent since entering REQ; cleared on every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == S_REQ || state == S_WAIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a real response always wins over the watchdog.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    capture      = 1'b0;
    timeout_fire = 1'b0;
    case (state)
      S_IDLE: begin
        if (hs_ex4ls_val) begin
          if (i_ls_ren || is_store) begin
            accept    = 1'b1;
            state_nxt = S_REQ;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_REQ: begin
        if (i_mem_gnt && i_mem_rvld) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_nxt    = S_RESP;
        end else if (i_mem_gnt) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_rvld) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else if (timeout_hit) begin
          timeout_fire = 1'b1;
          state_nxt    = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Latched request, captured response and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_ls4ex_rdy <= 1'b0;
      o_mem_req    <= 1'b0;
      o_ls_rdat    <= '0;
      o_ls_err     <= 1'b0;
      o_mem_adr    <= '0;
      o_mem_we     <= 1'b0;
      o_mem_be     <= '0;
      o_mem_wdat   <= '0;
    end else begin
      hs_ls4ex_rdy <= (state_nxt == S_RESP);
      o_mem_req    <= (state_nxt == S_REQ);
      if (state == S_IDLE && hs_ex4ls_val) begin
        o_ls_rdat <= '0;
        o_ls_err  <= 1'b0;
      end
      if (accept) begin
        o_mem_adr  <= {i_ls_adr[31:2], 2'b00};
        o_mem_wdat <= i_ls_wdat;
        o_mem_we   <= is_store;
        o_mem_be   <= is_store ? i_ls_wen : 4'hF;
      end
      if (capture) begin
        o_ls_rdat <= o_mem_we ? 32'h0 : i_mem_rdat;
        o_ls_err  <= i_mem_rerr;
      end
      if (timeout_fire) begin
        o_ls_rdat <= '0;
        o_ls_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu; covers the watchdog when CIRNO_LSU_TIMEOUT_EN is defined.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        hs_ex4ls_val;
  logic        hs_ls4ex_rdy;
  logic [31:0] i_ls_adr;
  logic [31:0] i_ls_wdat;
  logic [3:0]  i_ls_wen;
  logic        i_ls_ren;
  logic [31:0] o_ls_rdat;
  logic        o_ls_err;
  logic        o_mem_req;
  logic        i_mem_gnt;
  logic [31:0] o_mem_adr;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdat;
  logic        i_mem_rvld;
  logic [31:0] i_mem_rdat;
  logic        i_mem_rerr;

  int n_cmp = 0;
  int n_err = 0;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .hs_ex4ls_val(hs_ex4ls_val), .hs_ls4ex_rdy(hs_ls4ex_rdy),
    .i_ls_adr(i_ls_adr), .i_ls_wdat(i_ls_wdat), .i_ls_wen(i_ls_wen), .i_ls_ren(i_ls_ren),
    .o_ls_rdat(o_ls_rdat), .o_ls_err(o_ls_err),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_adr(o_mem_adr),
    .o_mem_we(o_mem_we), .o_mem_be(o_mem_be), .o_mem_wdat(o_mem_wdat),
    .i_mem_rvld(i_mem_rvld), .i_mem_rdat(i_mem_rdat), .i_mem_rerr(i_mem_rerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; hs_ex4ls_val = 1'b0; i_ls_adr = '0; i_ls_wdat = '0; i_ls_wen = '0;
    i_ls_ren = 1'b0; i_mem_gnt = 1'b0; i_mem_rvld = 1'b0; i_mem_rdat = '0; i_mem_rerr = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_rdy", 32'(hs_ls4ex_rdy), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_err", 32'(o_ls_err), 32'd0);
    chk("rst_we", 32'(o_mem_we), 32'd0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    chk("rst_adr", o_mem_adr, 32'd0);
    chk("rst_wdat", o_mem_wdat, 32'd0);
    chk("rst_rdat", o_ls_rdat, 32'd0);

    // Load, 1-cycle memory: accept T, gnt T+1, rvld T+2, rdy T+3
    rst = 1'b0; hs_ex4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_adr = 32'h0000_1003;
    tick();
    chk("ld_req", 32'(o_mem_req), 32'd1);
    chk("ld_adr", o_mem_adr, 32'h0000_1000);
    chk("ld_be", 32'(o_mem_be), 32'hF);
    chk("ld_we", 32'(o_mem_we), 32'd0);
    i_mem_gnt = 1'b1;
    tick();
    chk("ld_req_wait", 32'(o_mem_req), 32'd0);
    chk("ld_rdy_early", 32'(hs_ls4ex_rdy), 32'd0);
    i_mem_gnt = 1'b0; i_mem_rvld = 1'b1; i_mem_rdat = 32'hDEAD_BEEF;
    tick();
    chk("ld_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("ld_rdat", o_ls_rdat, 32'hDEAD_BEEF);
    chk("ld_err", 32'(o_ls_err), 32'd0);
    i_mem_rvld = 1'b0; hs_ex4ls_val = 1'b0; i_ls_ren = 1'b0;
    tick();
    chk("ld_rdy_drop", 32'(hs_ls4ex_rdy), 32'd0);

    // Store with grant delayed 3 cycles; request inputs change while busy
    hs_ex4ls_val = 1'b1; i_ls_wen = 4'b1100; i_ls_wdat = 32'hAABB_0000; i_ls_adr = 32'h0000_2006;
    tick();
    i_ls_adr = 32'hFFFF_FFFF; i_ls_wdat = 32'h1111_1111; i_ls_wen = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      chk("st_req_hold", 32'(o_mem_req), 32'd1);
      chk("st_adr", o_mem_adr, 32'h0000_2004);
      chk("st_wdat", o_mem_wdat, 32'hAABB_0000);
      chk("st_be", 32'(o_mem_be), 32'b1100);
      chk("st_we", 32'(o_mem_we), 32'd1);
      chk("st_rdy_early", 32'(hs_ls4ex_rdy), 32'd0);
      tick();
    end
    chk("st_req_at_gnt", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvld = 1'b1; i_mem_rdat = 32'h1234_5678;
    tick();
    chk("st_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("st_rdat", o_ls_rdat, 32'd0);
    chk("st_err", 32'(o_ls_err), 32'd0);
    i_mem_rvld = 1'b0; hs_ex4ls_val = 1'b0; i_ls_wen = 4'b0000;
    tick();
    chk("st_one_pulse", 32'(hs_ls4ex_rdy), 32'd0);

    // Same-cycle grant and response with error
    hs_ex4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_adr = 32'h0000_0030;
    tick();
    chk("sc_req", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1; i_mem_rvld = 1'b1; i_mem_rerr = 1'b1; i_mem_rdat = 32'h0000_0055;
    tick();
    chk("sc_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("sc_err", 32'(o_ls_err), 32'd1);
    chk("sc_rdat", o_ls_rdat, 32'h0000_0055);
    i_mem_gnt = 1'b0; i_mem_rvld = 1'b0; i_mem_rerr = 1'b0; hs_ex4ls_val = 1'b0; i_ls_ren = 1'b0;
    tick();

    // No-op then back-to-back load held on val
    hs_ex4ls_val = 1'b1;
    tick();
    chk("noop_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("noop_req", 32'(o_mem_req), 32'd0);
    chk("noop_rdat", o_ls_rdat, 32'd0);
    chk("noop_err", 32'(o_ls_err), 32'd0);
    i_ls_ren = 1'b1; i_ls_adr = 32'h0000_0044;
    tick();
    chk("b2b_idle_rdy", 32'(hs_ls4ex_rdy), 32'd0);
    chk("b2b_idle_req", 32'(o_mem_req), 32'd0);
    tick();
    chk("b2b_req", 32'(o_mem_req), 32'd1);
    chk("b2b_adr", o_mem_adr, 32'h0000_0044);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvld = 1'b1; i_mem_rdat = 32'hCAFE_F00D;
    tick();
    chk("b2b_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("b2b_rdat", o_ls_rdat, 32'hCAFE_F00D);
    i_mem_rvld = 1'b0; hs_ex4ls_val = 1'b0; i_ls_ren = 1'b0;
    tick();

    // Reset mid-WAIT, then a stray response in IDLE
    hs_ex4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_adr = 32'h0000_0080;
    tick();
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0; rst = 1'b1; hs_ex4ls_val = 1'b0; i_ls_ren = 1'b0;
    tick();
    rst = 1'b0;
    chk("rw_req", 32'(o_mem_req), 32'd0);
    chk("rw_adr_clr", o_mem_adr, 32'd0);
    chk("rw_rdy", 32'(hs_ls4ex_rdy), 32'd0);
    i_mem_rvld = 1'b1; i_mem_rdat = 32'h0000_0BAD;
    tick();
    chk("stray_rdy", 32'(hs_ls4ex_rdy), 32'd0);
    chk("stray_rdat", o_ls_rdat, 32'd0);
    i_mem_rvld = 1'b0;
    hs_ex4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_adr = 32'h0000_0090;
    tick();
    chk("post_rst_req", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1; i_mem_rvld = 1'b1; i_mem_rdat = 32'h0000_0777;
    tick();
    chk("post_rst_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("post_rst_rdat", o_ls_rdat, 32'h0000_0777);
    i_mem_gnt = 1'b0; i_mem_rvld = 1'b0; hs_ex4ls_val = 1'b0; i_ls_ren = 1'b0;
    tick();

    // Grant withheld: watchdog fires at accept+5, or the request stalls indefinitely
    hs_ex4ls_val = 1'b1; i_ls_ren = 1'b1; i_ls_adr = 32'h0000_0100;
    tick();
`ifdef CIRNO_LSU_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(o_mem_req), 32'd1);
      chk("to_rdy_early", 32'(hs_ls4ex_rdy), 32'd0);
      tick();
    end
    chk("to_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("to_err", 32'(o_ls_err), 32'd1);
    chk("to_rdat", o_ls_rdat, 32'd0);
    chk("to_req_drop", 32'(o_mem_req), 32'd0);
    hs_ex4ls_val = 1'b0; i_ls_ren = 1'b0;
    tick();
`else
    for (int i = 0; i < 8; i++) begin
      chk("stall_req", 32'(o_mem_req), 32'd1);
      chk("stall_rdy", 32'(hs_ls4ex_rdy), 32'd0);
      tick();
    end
    i_mem_gnt = 1'b1; i_mem_rvld = 1'b1; i_mem_rdat = 32'h0BAD_CAFE;
    tick();
    chk("stall_done_rdy", 32'(hs_ls4ex_rdy), 32'd1);
    chk("stall_done_err", 32'(o_ls_err), 32'd0);
    chk("stall_done_rdat", o_ls_rdat, 32'h0BAD_CAFE);
    i_mem_gnt = 1'b0; i_mem_rvld = 1'b0; hs_ex4ls_val = 1'b0; i_ls_ren = 1'b0;
    tick();
`endif
    chk("end_rdy", 32'(hs_ls4ex_rdy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
